// File: rtl/cache_fill_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter_pkg
//   Shared types and constants for the cache fill arbiter.
//   - state_e         : arbiter FSM states
//   - BLOCK_MASK      : clears the byte offset inside a 16-byte cache block
//   - WORDS_PER_BLOCK : 16-bit words transferred per block fill
//   - MEM_LATENCY     : main-memory read latency in cycles, issue cycle included
// -----------------------------------------------------------------------------
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_e;

  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
  localparam int          WORDS_PER_BLOCK = 8;
  localparam int          MEM_LATENCY     = 4;

endpackage : cache_fill_arbiter_pkg

// File: rtl/cache_fill_arbiter_fill_seq.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter_fill_seq
//   Block-fill sequencer: issues one word read per cycle for a whole block and
//   counts the returning words back in, overlapping issue and receive.
//
//   Ports
//     clk, rst_n      : clock, asynchronous active-low reset
//     start           : load a new block (one cycle, only while not active)
//     base            : miss byte address; the block offset is masked off here
//     active          : a fill owns the memory this cycle
//     mem_data_valid  : read data returning from memory
//     issue_addr      : byte address of the read issued this cycle
//     issue_en        : a read is issued this cycle
//     recv_we         : the returning word belongs to this fill, write it
//     recv_idx        : word index of the returning word
//     last            : recv_we for the final word of the block
// -----------------------------------------------------------------------------
module cache_fill_arbiter_fill_seq #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_fill_arbiter_pkg::WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = cache_fill_arbiter_pkg::MEM_LATENCY,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              active,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              issue_en,
  output logic              recv_we,
  output logic [IDX_W-1:0]  recv_idx,
  output logic              last
);

  import cache_fill_arbiter_pkg::*;

  localparam int                CNT_W     = IDX_W + 1;
  localparam int                PEND_W    = MEM_LATENCY - 1;
  localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(BLOCK_MASK);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
  // One bit per cycle of read latency: bit i set means a read issued by this
  // block i+1 cycles ago. Only data lined up with our own issue is accepted,
  // so returns for reads launched before a reset can never land in a new fill.
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] word_off;

  always_comb begin
    // NOTE: every signal assigned here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;

    issue_en = active && (issue_cnt_q < CNT_END);
    recv_we  = active && mem_data_valid && pend_q[PEND_W-1] && (recv_cnt_q < CNT_END);
    recv_idx = recv_cnt_q[IDX_W-1:0];
    last     = recv_we && (recv_cnt_q == CNT_LAST);

    // The word offset only occupies the masked-off low bits, so OR-ing it in
    // cannot carry into the block address: 0xFFF0 stays inside 0xFFF0..0xFFFE.
    word_off   = ADDR_W'({issue_cnt_q[IDX_W-1:0], 1'b0});
    issue_addr = base_q | word_off;

    pend_d = PEND_W'({pend_q, issue_en});

    if (start) begin
      base_d      = base & BASE_MASK;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_en) issue_cnt_d = issue_cnt_q + 1'b1;
      if (recv_we)  recv_cnt_d  = recv_cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  // NOTE: all sequencer state, including the latched base and the pending
  // pipe, is cleared on reset so nothing from an interrupted fill survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= '0;
    end else begin
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pend_q      <= pend_d;
    end
  end

endmodule : cache_fill_arbiter_fill_seq

// File: rtl/cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter
//   Grants the single-ported main memory to one requester at a time:
//   D-cache write-through stores, D-cache block fills and I-cache block fills
//   (priority in that order, evaluated only in IDLE). A fill issues one word
//   read per cycle and steers returning words into the owning cache.
//
//   Ports
//     clk, rst_n                          : clock, async active-low reset
//     i_miss, i_miss_addr                 : I-cache miss (held until i_fill_done)
//     d_miss, d_miss_addr                 : D-cache miss (held until d_fill_done)
//     d_wr_req, d_wr_addr, d_wr_data      : store request (held until d_wr_ack)
//     mem_en, mem_wr, mem_addr,
//     mem_data_in                         : memory command / write data
//     mem_data_out, mem_data_valid        : memory read return
//     fill_data, fill_word                : word being filled (shared)
//     i_fill_we, d_fill_we                : per-cache data-array write enables
//     i_fill_done, d_fill_done            : pulse with the last word of a fill
//     d_wr_ack                            : pulse, store accepted
//     busy                                : FSM is not in IDLE
// -----------------------------------------------------------------------------
module cache_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [ADDR_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  input  logic [ADDR_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  import cache_fill_arbiter_pkg::*;

  state_e            state_q, state_d;

  logic              seq_start;
  logic [ADDR_W-1:0] seq_base;
  logic              seq_active;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_en;
  logic              recv_we;
  logic [IDX_W-1:0]  recv_idx;
  logic              seq_last;

  assign seq_active = (state_q == FILL_I) || (state_q == FILL_D);

  cache_fill_arbiter_fill_seq #(
    .ADDR_W          (ADDR_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .MEM_LATENCY     (MEM_LATENCY)
  ) u_fill_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (seq_start),
    .base           (seq_base),
    .active         (seq_active),
    .mem_data_valid (mem_data_valid),
    .issue_addr     (issue_addr),
    .issue_en       (issue_en),
    .recv_we        (recv_we),
    .recv_idx       (recv_idx),
    .last           (seq_last)
  );

  always_comb begin
    state_d     = state_q;
    seq_start   = 1'b0;
    seq_base    = '0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // Requests are only arbitrated here; once granted, a transfer runs to
        // completion and anything raised meanwhile waits for the next IDLE.
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss) begin
          state_d   = FILL_D;
          seq_start = 1'b1;
          seq_base  = d_miss_addr;
        end else if (i_miss) begin
          state_d   = FILL_I;
          seq_start = 1'b1;
          seq_base  = i_miss_addr;
        end
      end

      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_d     = IDLE;
      end

      FILL_I, FILL_D: begin
        mem_en = issue_en;
        if (issue_en) mem_addr = issue_addr;
        if (recv_we) begin
          fill_data = mem_data_out;
          fill_word = recv_idx;
        end
        // The fill finishes even if the requester has dropped its miss.
        if (state_q == FILL_I) begin
          i_fill_we   = recv_we;
          i_fill_done = seq_last;
        end else begin
          d_fill_we   = recv_we;
          d_fill_done = seq_last;
        end
        if (seq_last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule : cache_fill_arbiter

// File: tb/tb_cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_arbiter
//   Directed bench for cache_fill_arbiter. A small memory model returns
//   (address ^ 16'h5A5A) three cycles after each read issue. Outputs are
//   sampled on the falling edge; inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_we      (i_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_we      (d_fill_we),
    .d_fill_done    (d_fill_done),
    .d_wr_ack       (d_wr_ack),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a read issued in cycle c returns valid data in cycle c+3.
  logic        vld [0:3];
  logic [15:0] adr [0:3];

  initial begin
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      adr[i] = 16'h0;
    end
    mem_data_valid = 1'b0;
    mem_data_out   = 16'h0;
  end

  always @(negedge clk) begin
    vld[0] = mem_en & ~mem_wr;
    adr[0] = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    vld[3] = vld[2]; adr[3] = adr[2];
    vld[2] = vld[1]; adr[2] = adr[1];
    vld[1] = vld[0]; adr[1] = adr[0];
    mem_data_valid = vld[3];
    mem_data_out   = vld[3] ? (adr[3] ^ 16'h5A5A) : 16'h0;
  end

  task automatic check(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_en"},      0, 32'(mem_en),      32'h0);
    check({tag, " mem_wr"},      0, 32'(mem_wr),      32'h0);
    check({tag, " mem_addr"},    0, 32'(mem_addr),    32'h0);
    check({tag, " mem_data_in"}, 0, 32'(mem_data_in), 32'h0);
    check({tag, " fill_data"},   0, 32'(fill_data),   32'h0);
    check({tag, " fill_word"},   0, 32'(fill_word),   32'h0);
    check({tag, " i_fill_we"},   0, 32'(i_fill_we),   32'h0);
    check({tag, " d_fill_we"},   0, 32'(d_fill_we),   32'h0);
    check({tag, " i_fill_done"}, 0, 32'(i_fill_done), 32'h0);
    check({tag, " d_fill_done"}, 0, 32'(d_fill_done), 32'h0);
    check({tag, " d_wr_ack"},    0, 32'(d_wr_ack),    32'h0);
    check({tag, " busy"},        0, 32'(busy),        32'h0);
  endtask

  // Checks cycles t+1..t+12 of a fill whose request was sampled at edge t.
  // The request is dropped right after the done cycle is checked; a store
  // request is raised at cycle t+wr_at when wr_at is nonzero.
  task automatic fill_check(input string tag, input bit is_i,
                            input logic [15:0] base, input int wr_at);
    logic        exp_en, exp_we;
    logic [15:0] exp_addr, exp_data;
    logic [2:0]  exp_word;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_en   = (k <= 8);
      exp_addr = exp_en ? base + 16'(2 * (k - 1)) : 16'h0;
      exp_we   = (k >= 4) && (k <= 11);
      exp_word = exp_we ? 3'(k - 4) : 3'h0;
      exp_data = exp_we ? ((base + 16'(2 * (k - 4))) ^ 16'h5A5A) : 16'h0;
      check({tag, " mem_en"},      k, 32'(mem_en),      32'(exp_en));
      check({tag, " mem_addr"},    k, 32'(mem_addr),    32'(exp_addr));
      check({tag, " mem_wr"},      k, 32'(mem_wr),      32'h0);
      check({tag, " mem_data_in"}, k, 32'(mem_data_in), 32'h0);
      check({tag, " i_fill_we"},   k, 32'(i_fill_we),   32'(is_i & exp_we));
      check({tag, " d_fill_we"},   k, 32'(d_fill_we),   32'(!is_i & exp_we));
      check({tag, " fill_word"},   k, 32'(fill_word),   32'(exp_word));
      check({tag, " fill_data"},   k, 32'(fill_data),   32'(exp_data));
      check({tag, " i_fill_done"}, k, 32'(i_fill_done), 32'(is_i && k == 11));
      check({tag, " d_fill_done"}, k, 32'(d_fill_done), 32'(!is_i && k == 11));
      check({tag, " d_wr_ack"},    k, 32'(d_wr_ack),    32'h0);
      check({tag, " busy"},        k, 32'(busy),        32'(k <= 11));
      if (k == wr_at) d_wr_req = 1'b1;
      if (k == 11) begin
        if (is_i) i_miss = 1'b0;
        else      d_miss = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    i_miss      = 1'b0;
    i_miss_addr = 16'h0;
    d_miss      = 1'b0;
    d_miss_addr = 16'h0;
    d_wr_req    = 1'b0;
    d_wr_addr   = 16'h0;
    d_wr_data   = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // I miss only
    i_miss      = 1'b1;
    i_miss_addr = 16'h1234;
    fill_check("ifill", 1'b1, 16'h1230, 0);

    // Simultaneous D and I miss: D first, I issue starts 12 cycles later
    d_miss      = 1'b1;
    d_miss_addr = 16'h0408;
    i_miss      = 1'b1;
    i_miss_addr = 16'h2000;
    fill_check("dfirst", 1'b0, 16'h0400, 0);
    fill_check("ithen", 1'b1, 16'h2000, 0);

    // Single store
    d_wr_req  = 1'b1;
    d_wr_addr = 16'h00A2;
    d_wr_data = 16'hBEEF;
    @(negedge clk);
    check("wr mem_en",      0, 32'(mem_en),      32'h1);
    check("wr mem_wr",      0, 32'(mem_wr),      32'h1);
    check("wr mem_addr",    0, 32'(mem_addr),    32'h00A2);
    check("wr mem_data_in", 0, 32'(mem_data_in), 32'hBEEF);
    check("wr d_wr_ack",    0, 32'(d_wr_ack),    32'h1);
    check("wr busy",        0, 32'(busy),        32'h1);
    d_wr_req = 1'b0;
    @(negedge clk);
    check_all_zero("after wr");

    // Store raised during an I fill waits for the fill to finish
    i_miss      = 1'b1;
    i_miss_addr = 16'h4006;
    d_wr_addr   = 16'h1110;
    d_wr_data   = 16'h1234;
    fill_check("ifill+wr", 1'b1, 16'h4000, 3);
    @(negedge clk);
    check("late wr mem_wr",      0, 32'(mem_wr),      32'h1);
    check("late wr mem_addr",    0, 32'(mem_addr),    32'h1110);
    check("late wr mem_data_in", 0, 32'(mem_data_in), 32'h1234);
    check("late wr d_wr_ack",    0, 32'(d_wr_ack),    32'h1);
    d_wr_req = 1'b0;
    @(negedge clk);
    check_all_zero("after late wr");

    // Top-of-memory block: no wrap to 0x0000
    d_miss      = 1'b1;
    d_miss_addr = 16'hFFFA;
    fill_check("dtop", 1'b0, 16'hFFF0, 0);

    // Reset in the middle of a fill
    i_miss      = 1'b1;
    i_miss_addr = 16'h3000;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    check("pre-rst mem_addr", 6, 32'(mem_addr), 32'h300A);
    #2;
    rst_n  = 1'b0;
    i_miss = 1'b0;
    #1;
    check_all_zero("async rst");
    @(negedge clk);
    check_all_zero("rst held");
    rst_n = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      @(negedge clk);
      check("stale i_fill_we", k, 32'(i_fill_we), 32'h0);
      check("stale d_fill_we", k, 32'(d_fill_we), 32'h0);
      check("stale busy",      k, 32'(busy),      32'h0);
    end

    // Fresh fill after reset starts from word 0
    i_miss      = 1'b1;
    i_miss_addr = 16'h5678;
    fill_check("post-rst", 1'b1, 16'h5670, 0);

    @(negedge clk);
    check_all_zero("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cache_fill_arbiter
